mul_pipeline: RTL and testbench

Parametrised multiply execution pipeline. It replaces the fixed M2..M5 register chain of the core's MUL path.
- Accepts MUL-type instructions leaving the E/M boundary and computes the RV32M MUL/MULH/MULHSU/MULHU result.
- Carries the result through a configurable number of stages, with stall and flush support.
- Presents a penultimate-stage bypass tap and a writeback port to decode and the ROB.

---
 rtl/mul_pipeline.sv | 167 ++++++++++++++++
 tb/tb_mul_pipeline.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_pipeline.sv
// Multiply execution pipeline: accepts RV32M MUL/MULH/MULHSU/MULHU ops,
// computes the product in stage 2 and shifts the result through a
// configurable number of stages with stall, flush, bypass tap and writeback.

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 6
`endif

// Flags ops with div/rem encodings (funct3 = 1xx) that reach stage 1.
module mul_pipeline_chk (
  input logic       clk,
  input logic       rst,
  input logic       valid1,
  input logic [2:0] funct3
);

  a_no_divrem : assert property (@(posedge clk) disable iff (rst) valid1 |-> !funct3[2]);

endmodule

module mul_pipeline #(
  parameter int WORD_SIZE = `WORD_SIZE,
  parameter int ROB_ID_W  = `ROB_ENTRY_WIDTH,
  parameter int STAGES    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [2:0]           in_funct3,
  input  logic [WORD_SIZE-1:0] in_s1,
  input  logic [WORD_SIZE-1:0] in_s2,
  input  logic [WORD_SIZE-1:0] in_pc,
  input  logic [ROB_ID_W-1:0]  in_rob_id,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 byp_valid,
  output logic [WORD_SIZE-1:0] byp_result,
  output logic [ROB_ID_W-1:0]  byp_rob_id,
  output logic                 out_valid,
  output logic [WORD_SIZE-1:0] out_result,
  output logic [WORD_SIZE-1:0] out_pc,
  output logic [ROB_ID_W-1:0]  out_rob_id,
  output logic                 busy
);

  // Stage 1: captured operands and instruction metadata.
  logic                 v1_r;
  logic [2:0]           f3_r;
  logic [WORD_SIZE-1:0] s1_r;
  logic [WORD_SIZE-1:0] s2_r;
  logic [WORD_SIZE-1:0] pc1_r;
  logic [ROB_ID_W-1:0]  rob1_r;

  // Stages 2..STAGES: result-carrying shift chain.
  logic [STAGES:2]      v_r;
  logic [WORD_SIZE-1:0] res_r [2:STAGES];
  logic [WORD_SIZE-1:0] pc_r  [2:STAGES];
  logic [ROB_ID_W-1:0]  rob_r [2:STAGES];

  // Product datapath. Both operands are extended to 2*WORD_SIZE bits
  // according to their signedness; the low 2*WORD_SIZE bits of the
  // unsigned product of the extended values equal the true product.
  logic                   s1_signed_s;
  logic                   s2_signed_s;
  logic [2*WORD_SIZE-1:0] a_ext_s;
  logic [2*WORD_SIZE-1:0] b_ext_s;
  logic [2*WORD_SIZE-1:0] prod_s;
  logic [WORD_SIZE-1:0]   sel_s;

  assign s1_signed_s = (f3_r == 3'b000) || (f3_r == 3'b001) || (f3_r == 3'b010);
  assign s2_signed_s = (f3_r == 3'b000) || (f3_r == 3'b001);
  assign a_ext_s     = {{WORD_SIZE{s1_signed_s & s1_r[WORD_SIZE-1]}}, s1_r};
  assign b_ext_s     = {{WORD_SIZE{s2_signed_s & s2_r[WORD_SIZE-1]}}, s2_r};
  assign prod_s      = a_ext_s * b_ext_s;

  // Select the low word for MUL, the high word for the MULH variants, 0 otherwise.
  always_comb begin
    sel_s = '0;
    case (f3_r)
      3'b000:  sel_s = prod_s[WORD_SIZE-1:0];
      3'b001:  sel_s = prod_s[2*WORD_SIZE-1:WORD_SIZE];
      3'b010:  sel_s = prod_s[2*WORD_SIZE-1:WORD_SIZE];
      3'b011:  sel_s = prod_s[2*WORD_SIZE-1:WORD_SIZE];
      default: sel_s = '0;
    endcase
  end

  // Stage 1 accept: flush drops everything, stall holds, otherwise take the input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r   <= 1'b0;
      f3_r   <= 3'b000;
      s1_r   <= '0;
      s2_r   <= '0;
      pc1_r  <= '0;
      rob1_r <= '0;
    end else if (flush) begin
      v1_r <= 1'b0;
    end else if (!stall) begin
      v1_r <= in_valid;
      if (in_valid) begin
        f3_r   <= in_funct3;
        s1_r   <= in_s1;
        s2_r   <= in_s2;
        pc1_r  <= in_pc;
        rob1_r <= in_rob_id;
      end
    end
  end

  // Stages 2..STAGES: register the selected product, then shift forward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 2; i <= STAGES; i++) begin
        v_r[i]   <= 1'b0;
        res_r[i] <= '0;
        pc_r[i]  <= '0;
        rob_r[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 2; i <= STAGES; i++) begin
        v_r[i] <= 1'b0;
      end
    end else if (!stall) begin
      v_r[2]   <= v1_r;
      res_r[2] <= sel_s;
      pc_r[2]  <= pc1_r;
      rob_r[2] <= rob1_r;
      for (int i = 3; i <= STAGES; i++) begin
        v_r[i]   <= v_r[i-1];
        res_r[i] <= res_r[i-1];
        pc_r[i]  <= pc_r[i-1];
        rob_r[i] <= rob_r[i-1];
      end
    end
  end

  // Bypass tap from stage STAGES-1; with only two stages, stage 1 has no result yet.
  generate
    if (STAGES > 2) begin : g_byp
      assign byp_valid  = v_r[STAGES-1];
      assign byp_result = res_r[STAGES-1];
      assign byp_rob_id = rob_r[STAGES-1];
    end else begin : g_no_byp
      assign byp_valid  = 1'b0;
      assign byp_result = '0;
      assign byp_rob_id = '0;
    end
  endgenerate

  assign out_valid  = v_r[STAGES];
  assign out_result = res_r[STAGES];
  assign out_pc     = pc_r[STAGES];
  assign out_rob_id = rob_r[STAGES];
  assign busy       = v1_r | (|v_r);

  mul_pipeline_chk u_chk (
    .clk    (clk),
    .rst    (rst),
    .valid1 (v1_r),
    .funct3 (f3_r)
  );

endmodule

// File: tb/tb_mul_pipeline.sv
// Bench for mul_pipeline: a 4-stage and a 2-stage instance share one
// stimulus stream. A queue-based model (each op tagged with its age in
// advancing cycles) predicts every output; directed tests pin literal values.
module tb_mul_pipeline;

  localparam int W = 32;
  localparam int R = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [2:0]   in_funct3 = 3'b000;
  logic [W-1:0] in_s1 = '0, in_s2 = '0, in_pc = '0;
  logic [R-1:0] in_rob_id = '0;
  logic         stall = 1'b0, flush = 1'b0;

  logic         bv4, ov4, busy4, bv2, ov2, busy2;
  logic [W-1:0] bres4, ores4, opc4, bres2, ores2, opc2;
  logic [R-1:0] brob4, orob4, brob2, orob2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mul_pipeline #(.WORD_SIZE(W), .ROB_ID_W(R), .STAGES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_funct3(in_funct3),
    .in_s1(in_s1), .in_s2(in_s2), .in_pc(in_pc), .in_rob_id(in_rob_id),
    .stall(stall), .flush(flush),
    .byp_valid(bv4), .byp_result(bres4), .byp_rob_id(brob4),
    .out_valid(ov4), .out_result(ores4), .out_pc(opc4), .out_rob_id(orob4),
    .busy(busy4));

  mul_pipeline #(.WORD_SIZE(W), .ROB_ID_W(R), .STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_funct3(in_funct3),
    .in_s1(in_s1), .in_s2(in_s2), .in_pc(in_pc), .in_rob_id(in_rob_id),
    .stall(stall), .flush(flush),
    .byp_valid(bv2), .byp_result(bres2), .byp_rob_id(brob2),
    .out_valid(ov2), .out_result(ores2), .out_pc(opc2), .out_rob_id(orob2),
    .busy(busy2));

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] pc;
    logic [R-1:0] rob;
    int           age;
  } op_t;

  op_t mq [2][$];
  int  st [2] = '{4, 2};

  // Architectural RV32M result from plain 64-bit arithmetic.
  function automatic logic [W-1:0] ref_mul(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa, sb, ub, p;
    longint unsigned uu;
    sa = $signed(a);
    sb = $signed(b);
    ub = {32'd0, b};
    case (f3)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin uu = {32'd0, a} * {32'd0, b}; return uu[63:32]; end
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: an op accepted at an edge has age 1, gains one per non-stalled
  // edge, and is visible at the writeback when its age equals the depth.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq[0].delete();
      mq[1].delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (flush) begin
          mq[d].delete();
        end else if (!stall) begin
          foreach (mq[d][k]) mq[d][k].age++;
          while (mq[d].size() > 0 && mq[d][0].age > st[d]) void'(mq[d].pop_front());
          if (in_valid) mq[d].push_back('{ref_mul(in_funct3, in_s1, in_s2), in_pc, in_rob_id, 1});
        end
      end
    end
  end

  task automatic cmp_dut(input int d, input logic ov, input logic [W-1:0] ores, input logic [W-1:0] opc,
                         input logic [R-1:0] orob, input logic bv, input logic [W-1:0] bres,
                         input logic [R-1:0] brob, input logic busy);
    logic  eo, eb;
    op_t   oo, bo;
    string p;
    p  = (d == 0) ? "s4" : "s2";
    eo = 1'b0;
    eb = 1'b0;
    oo = '{'0, '0, '0, 0};
    bo = '{'0, '0, '0, 0};
    foreach (mq[d][k]) begin
      if (mq[d][k].age == st[d]) begin eo = 1'b1; oo = mq[d][k]; end
      if (st[d] > 2 && mq[d][k].age == st[d] - 1) begin eb = 1'b1; bo = mq[d][k]; end
    end
    chk({p, " out_valid"}, ov, eo);
    chk({p, " byp_valid"}, bv, eb);
    chk({p, " busy"}, busy, mq[d].size() != 0);
    if (eo) begin
      chk({p, " out_result"}, ores, oo.res);
      chk({p, " out_pc"}, opc, oo.pc);
      chk({p, " out_rob_id"}, orob, oo.rob);
    end
    if (eb) begin
      chk({p, " byp_result"}, bres, bo.res);
      chk({p, " byp_rob_id"}, brob, bo.rob);
    end
    if (rst) begin
      chk({p, " rst out_result"}, ores, 0);
      chk({p, " rst out_pc"}, opc, 0);
      chk({p, " rst out_rob_id"}, orob, 0);
      chk({p, " rst byp_result"}, bres, 0);
    end
  endtask

  // Compare both instances against the model away from the active edge.
  always @(negedge clk) begin
    cmp_dut(0, ov4, ores4, opc4, orob4, bv4, bres4, brob4, busy4);
    cmp_dut(1, ov2, ores2, opc2, orob2, bv2, bres2, brob2, busy2);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] pc, input logic [R-1:0] rob);
    in_valid  = 1'b1;
    in_funct3 = f3;
    in_s1     = a;
    in_s2     = b;
    in_pc     = pc;
    in_rob_id = rob;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [W-1:0] mexp [4];

  initial begin
    rst = 1'b1;
    step();
    step();
    chk("reset out_valid", ov4, 0);
    chk("reset out_result", ores4, 0);
    chk("reset out_rob_id", orob4, 0);
    chk("reset busy", busy4, 0);
    rst = 1'b0;
    step();

    // MUL 7*6: bypass one cycle before writeback, 2-stage instance after 2 cycles.
    send(3'b000, 32'd7, 32'd6, 32'h100, 6'd3);
    step();
    idle();
    chk("s2 lat1 out_valid", ov2, 0);
    step();
    chk("s2 lat2 out_valid", ov2, 1);
    chk("s2 lat2 out_result", ores2, 42);
    step();
    chk("7x6 byp_valid", bv4, 1);
    chk("7x6 byp_result", bres4, 42);
    chk("7x6 early out_valid", ov4, 0);
    step();
    chk("7x6 out_valid", ov4, 1);
    chk("7x6 out_result", ores4, 42);
    chk("7x6 out_rob_id", orob4, 3);
    chk("7x6 out_pc", opc4, 32'h100);
    step();
    chk("7x6 pulse ends", ov4, 0);

    // Four back-to-back modes with s1=-1, s2=2.
    mexp[0] = 32'hFFFF_FFFE;
    mexp[1] = 32'hFFFF_FFFF;
    mexp[2] = 32'hFFFF_FFFF;
    mexp[3] = 32'h0000_0001;
    for (int i = 0; i < 4; i++) begin
      send(i[2:0], 32'hFFFF_FFFF, 32'h0000_0002, 32'h200 + i, i[5:0]);
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      chk("mode out_valid", ov4, 1);
      chk("mode out_rob_id", orob4, i);
      chk("mode out_result", ores4, mexp[i]);
      step();
    end
    chk("mode train ends", ov4, 0);

    // MULH most-negative squared.
    send(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h300, 6'd5);
    step();
    idle();
    step();
    step();
    step();
    chk("mulh min out_valid", ov4, 1);
    chk("mulh min out_result", ores4, 32'h4000_0000);

    // Stall for three cycles with an op two stages in; offered op must be ignored.
    step();
    send(3'b000, 32'd1000, 32'd3, 32'h400, 6'd7);
    step();
    idle();
    step();
    stall = 1'b1;
    send(3'b000, 32'd9, 32'd9, 32'h404, 6'd9);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall out_valid", ov4, 0);
      chk("stall busy", busy4, 1);
    end
    stall = 1'b0;
    idle();
    step();
    chk("stall late out_valid", ov4, 0);
    step();
    chk("stall out_valid", ov4, 1);
    chk("stall out_result", ores4, 3000);
    chk("stall out_rob_id", orob4, 7);
    step();
    chk("stalled input dropped", ov4, 0);

    // Flush with stall and in_valid: everything in flight disappears.
    for (int i = 0; i < 3; i++) begin
      send(3'b000, 32'd11 + i, 32'd2, 32'h500 + i, 6'd10 + i[5:0]);
      step();
    end
    flush = 1'b1;
    stall = 1'b1;
    send(3'b000, 32'd13, 32'd13, 32'h510, 6'd15);
    step();
    flush = 1'b0;
    stall = 1'b0;
    idle();
    chk("flush busy4", busy4, 0);
    chk("flush busy2", busy2, 0);
    repeat (6) step();
    send(3'b000, 32'd5, 32'd5, 32'h600, 6'd20);
    step();
    idle();
    step();
    step();
    chk("post-flush early", ov4, 0);
    step();
    chk("post-flush out_valid", ov4, 1);
    chk("post-flush out_result", ores4, 25);

    // Asynchronous reset between edges with two ops in flight.
    step();
    send(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 32'h700, 6'd30);
    step();
    send(3'b010, 32'hF000_0000, 32'h0000_0010, 32'h704, 6'd31);
    step();
    idle();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("async rst byp_valid", bv4, 0);
    chk("async rst byp_result", bres4, 0);
    chk("async rst busy", busy4, 0);
    chk("async rst s2 out_valid", ov2, 0);
    chk("async rst s2 out_result", ores2, 0);
    step();
    rst = 1'b0;
    step();

    // Randomized traffic with stalls and occasional flushes.
    repeat (3000) begin
      if ($urandom_range(0, 3) != 0) begin
        send($urandom_range(0, 3), pick_operand(), pick_operand(), $urandom, $urandom_range(0, 63));
      end else begin
        idle();
      end
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 24) == 0);
      step();
    end
    idle();
    stall = 1'b0;
    flush = 1'b0;
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
